regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port between several writeback requesters: the ALU, the load unit and the multiply/divide unit. It arbitrates one write per cycle and registers the winner onto the regfile write port (`rd_we`/`rd_num`/`rd_data`). It also sequences halt: it drains all pending writes before raising `halted`, which triggers the regfile dump.

## Interface
Parameters:
- XLEN, 32, data width of register writes
- NREQ, 3, number of requesters (index 0 = ALU, 1 = load, 2 = mul/div)

Ports:
- clk  input  1  clock; all state changes on posedge
- rst_b  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_ready  output  NREQ  write from requester i accepted this cycle
- req_num  input  NREQ×5  destination register index per requester
- req_data  input  NREQ×XLEN  write data per requester
- halt_req  input  1  halt request; level or pulse, sampled each cycle
- rd_we  output  1  regfile write enable
- rd_num  output  5  regfile write index
- rd_data  output  XLEN  regfile write data
- halted  output  1  all writes retired; sticky until reset
- busy  output  1  output register holds a write, or any req_valid is high

## Operation
- Handshake:
  - A write transfers when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid and state; at most one bit is set per cycle.
  - A requester holds valid, num and data stable until accepted.
- Arbitration:
  - Only in RUN or DRAIN.
  - The first valid requester searching from rr_ptr upward, wrapping modulo NREQ, wins.
  - After a grant to i, rr_ptr becomes (i+1) mod NREQ. rr_ptr is unchanged when there is no grant.
- Output register:
  - The accepted write is loaded into the rd_* registers on the next edge.
  - rd_we is 0 when req_num == 0: the slot is consumed and the handshake completes, but r0 is never written.
  - With no grant, rd_we is 0 and rd_num/rd_data hold their last values.
- FSM:
  - RUN → DRAIN when halt_req=1.
  - DRAIN: arbitration continues. DRAIN → HALTED on the first cycle where all req_valid=0 and rd_we=0.
  - HALTED: req_ready=0, rd_we=0, halted=1. Only reset leaves HALTED.
- halt_req in DRAIN or HALTED is ignored.
- Simultaneous halt_req and grant in RUN: the grant is honoured and the state moves to DRAIN.
- Reset mid-operation: any pending output write is discarded (rd_we forced 0); requesters must re-present.

## Timing
- Reset values: rd_we=0, rd_num=0, rd_data=0, halted=0, req_ready=0, rr_ptr=0, state RUN. busy=0 once inputs are low.
- Latency, accept to rd_we=1: 1 cycle. The regfile captures the write at the following edge, 2 edges after acceptance.
- Throughput: 1 write per cycle sustained; no bubbles between back-to-back grants.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- halted rises exactly 1 cycle after the drain condition is met. The condition is evaluated on registered rd_we, so the last write has been captured by the regfile before the dump.

## Configuration
- REGFILE_ARB_RR_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, lowest index wins, and rr_ptr is removed. Requester 0 (ALU) can then starve the others; this mode is intended for single-issue debug builds.
- All other behaviour is identical in both modes.

## Structure
- Shared package regfile_arb_pkg:
  - state enum {ARB_RUN, ARB_DRAIN, ARB_HALTED}
  - wb_req_t struct {num[4:0], data[XLEN-1:0]}
  - REG_ZERO constant (5'd0)
- Sub-module rr_pick:
  - Combinational one-hot picker with inputs valid vector and start pointer.
  - Outputs a one-hot grant and the encoded index.
  - Reused by the fixed-priority mode with start pointer tied to 0.

## Test plan
- Single write: ALU valid, num=5, data=0xDEADBEEF → ready same cycle; rd_we=1, rd_num=5, rd_data=0xDEADBEEF one cycle later.
- Contention:
  - RR: all three valid for 6 cycles from reset → grants 0,1,2,0,1,2.
  - Fixed priority (macro off): grants 0,0,0,0,0,0.
- r0 write: load unit valid, num=0, data=0x1234 → ready=1, rd_we stays 0; rr_ptr advances to 2.
- Halt with pending writes: halt_req pulse while mul/div valid (num=8) and load valid (num=9) → both accepted, rd_we for r8 then r9; halted=1 exactly 1 cycle after r9's rd_we falls; ready=0 afterwards.
- Halt while idle: halt_req=1, no valid → DRAIN for 1 cycle, halted=1 two cycles after halt_req; later req_valid is never acknowledged.
- Async reset mid-stream: rst_b low between acceptance and rd_we → rd_we=0 immediately, halted=0, state RUN; after release, rr_ptr=0 and requester 0 wins first.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_arb_pkg;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_HALTED
  } arb_state_e;

  typedef struct packed {
    logic [4:0]         num;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// One-hot picker: first valid bit at or above start_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] start_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_any
);

  logic [IDXW:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, start_ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!grant_any && valid[cand[IDXW-1:0]]) begin
        grant_any                = 1'b1;
        grant[cand[IDXW-1:0]]    = 1'b1;
        grant_idx                = cand[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates requesters onto the single regfile write port and sequences halt.
// REGFILE_ARB_RR_EN selects round-robin; undefined gives fixed priority (index 0 highest).
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*5-1:0]  req_num,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic               halt_req,
  output logic               rd_we,
  output logic [4:0]         rd_num,
  output logic [XLEN-1:0]    rd_data,
  output logic               halted,
  output logic               busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic            grant_en;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] start_ptr;
  logic            grant_any;
  logic            accept_p0;
  logic [4:0]      num_p0;
  logic [XLEN-1:0] data_p0;
  logic            vld_p1;
  logic [4:0]      num_p1;
  logic [XLEN-1:0] data_p1;

`ifdef REGFILE_ARB_RR_EN
  logic [IDXW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr <= '0;
    end else if (accept_p0) begin
      rr_ptr <= (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + IDXW'(1);
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .valid     (req_valid),
    .start_ptr (start_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // p0: grant selection and write mux
  assign req_ready = grant_en ? grant : '0;
  assign accept_p0 = grant_en && grant_any;

  always_comb begin
    num_p0  = REG_ZERO;
    data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        num_p0  = req_num[i*5 +: 5];
        data_p0 = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // p1: registered regfile write port; r0 grants are consumed without a write
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p1  <= 1'b0;
      num_p1  <= REG_ZERO;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0 && (num_p0 != REG_ZERO);
      if (accept_p0 && (num_p0 != REG_ZERO)) begin
        num_p1  <= num_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rd_we   = vld_p1;
  assign rd_num  = num_p1;
  assign rd_data = data_p1;
  assign busy    = vld_p1 || (|req_valid);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ARB_RUN;
    else        state_q <= state_d;
  end

  // Drain completes on registered rd_we so the last write lands before the dump.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN:    if (halt_req) state_d = ARB_DRAIN;
      ARB_DRAIN:  if (!(|req_valid) && !vld_p1) state_d = ARB_HALTED;
      ARB_HALTED: state_d = ARB_HALTED;
      default:    state_d = ARB_RUN;
    endcase
  end

  always_comb begin
    grant_en = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ARB_RUN, ARB_DRAIN: grant_en = 1'b1;
      ARB_HALTED:         halted   = 1'b1;
      default:            grant_en = 1'b0;
    endcase
  end

endmodule
